// File: rtl/equeue_int_if.sv
`default_nettype none
// ============================================================================
// Module   : equeue_int_if
// Brief    : Enqueue, CDB snoop and issue bundle for the integer issue queue.
// Revision : 1.0
// ============================================================================
interface equeue_int_if #(
  parameter int DEPTH  = 4,
  parameter int W_TAG  = 6,
  parameter int W_DATA = 32
);
  localparam int c_w_cnt = $clog2(DEPTH) + 1;

  logic [15:0]        equeue_imm;
  logic [W_TAG-1:0]   equeue_rdtag;
  logic [W_TAG-1:0]   equeue_rstag;
  logic [W_TAG-1:0]   equeue_rttag;
  logic [W_DATA-1:0]  equeue_rsdata;
  logic [W_DATA-1:0]  equeue_rtdata;
  logic               equeue_rsvalid;
  logic               equeue_rtvalid;
  logic [3:0]         equeueint_opcode;
  logic               equeueint_en;
  logic               equeueint_ready;

  logic [W_TAG-1:0]   cdb_tag;
  logic               cdb_valid;
  logic [W_DATA-1:0]  cdb_data;

  logic               issue_valid;
  logic               issue_ready;
  logic [3:0]         issue_opcode;
  logic [W_DATA-1:0]  issue_rsdata;
  logic [W_DATA-1:0]  issue_rtdata;
  logic [15:0]        issue_imm;
  logic [W_TAG-1:0]   issue_rdtag;
  logic [c_w_cnt-1:0] count;

  modport master (
    output equeue_imm, equeue_rdtag, equeue_rstag, equeue_rttag,
    output equeue_rsdata, equeue_rtdata, equeue_rsvalid, equeue_rtvalid,
    output equeueint_opcode, equeueint_en,
    output cdb_tag, cdb_valid, cdb_data,
    output issue_ready,
    input  equeueint_ready, issue_valid, issue_opcode, issue_rsdata,
    input  issue_rtdata, issue_imm, issue_rdtag, count
  );

  modport slave (
    input  equeue_imm, equeue_rdtag, equeue_rstag, equeue_rttag,
    input  equeue_rsdata, equeue_rtdata, equeue_rsvalid, equeue_rtvalid,
    input  equeueint_opcode, equeueint_en,
    input  cdb_tag, cdb_valid, cdb_data,
    input  issue_ready,
    output equeueint_ready, issue_valid, issue_opcode, issue_rsdata,
    output issue_rtdata, issue_imm, issue_rdtag, count
  );
endinterface
`default_nettype wire

// File: rtl/equeue_int.sv
`default_nettype none
// ============================================================================
// Module   : equeue_int
// Brief    : Compacting, age-ordered integer issue queue with CDB wake-up.
//            Define EQUEUEINT_WAKEUP_BYPASS_EN for same-cycle wake-to-issue.
// Revision : 1.0
// ============================================================================
module equeue_int #(
  parameter int DEPTH  = 4,
  parameter int W_TAG  = 6,
  parameter int W_DATA = 32
) (
  input wire          clk,
  input wire          reset,
  equeue_int_if.slave bus
);
  localparam int c_w_cnt = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              busy;
    logic [3:0]        opcode;
    logic [15:0]       imm;
    logic [W_TAG-1:0]  rdtag;
    logic [W_TAG-1:0]  rstag;
    logic [W_TAG-1:0]  rttag;
    logic [W_DATA-1:0] rsdata;
    logic [W_DATA-1:0] rtdata;
    logic              rsvalid;
    logic              rtvalid;
  } entry_t;

  entry_t             r_q   [DEPTH];
  entry_t             w_wk  [DEPTH+1];
  entry_t             w_nxt [DEPTH];
  entry_t             w_new;
  logic [c_w_cnt-1:0] r_count;
  logic [c_w_cnt-1:0] w_count_nxt;
  logic [c_w_cnt-1:0] w_sel;
  logic [c_w_cnt-1:0] w_wr_idx;
  logic [DEPTH-1:0]   w_wake_rs;
  logic [DEPTH-1:0]   w_wake_rt;
  logic [DEPTH-1:0]   w_rdy;
  logic [W_DATA-1:0]  w_eff_rs [DEPTH];
  logic [W_DATA-1:0]  w_eff_rt [DEPTH];
  logic               w_sel_found;
  logic               w_deq;
  logic               w_enq;
  logic               w_ready;

  logic [3:0]         w_iss_opcode;
  logic [W_DATA-1:0]  w_iss_rsdata;
  logic [W_DATA-1:0]  w_iss_rtdata;
  logic [15:0]        w_iss_imm;
  logic [W_TAG-1:0]   w_iss_rdtag;

  // Per-entry wake detection and effective operand state seen by select.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_wake_rs[g] = r_q[g].busy & ~r_q[g].rsvalid & bus.cdb_valid &
                          (bus.cdb_tag == r_q[g].rstag);
    assign w_wake_rt[g] = r_q[g].busy & ~r_q[g].rtvalid & bus.cdb_valid &
                          (bus.cdb_tag == r_q[g].rttag);
`ifdef EQUEUEINT_WAKEUP_BYPASS_EN
    assign w_rdy[g]    = r_q[g].busy & (r_q[g].rsvalid | w_wake_rs[g]) &
                         (r_q[g].rtvalid | w_wake_rt[g]);
    assign w_eff_rs[g] = w_wake_rs[g] ? bus.cdb_data : r_q[g].rsdata;
    assign w_eff_rt[g] = w_wake_rt[g] ? bus.cdb_data : r_q[g].rtdata;
`else
    assign w_rdy[g]    = r_q[g].busy & r_q[g].rsvalid & r_q[g].rtvalid;
    assign w_eff_rs[g] = r_q[g].rsdata;
    assign w_eff_rt[g] = r_q[g].rtdata;
`endif
  end

  // Oldest-first select; outputs stay zero when nothing is issuable.
  always_comb begin
    w_sel_found  = 1'b0;
    w_sel        = '0;
    w_iss_opcode = '0;
    w_iss_rsdata = '0;
    w_iss_rtdata = '0;
    w_iss_imm    = '0;
    w_iss_rdtag  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rdy[i] && !w_sel_found) begin
        w_sel_found  = 1'b1;
        w_sel        = c_w_cnt'(i);
        w_iss_opcode = r_q[i].opcode;
        w_iss_rsdata = w_eff_rs[i];
        w_iss_rtdata = w_eff_rt[i];
        w_iss_imm    = r_q[i].imm;
        w_iss_rdtag  = r_q[i].rdtag;
      end
    end
  end

  assign w_ready = (r_count < c_w_cnt'(DEPTH));
  assign w_deq   = w_sel_found & bus.issue_ready;
  assign w_enq   = bus.equeueint_en & w_ready;

  // Incoming entry, capturing a same-cycle broadcast so no wakeup is lost.
  always_comb begin
    w_new         = '0;
    w_new.busy    = 1'b1;
    w_new.opcode  = bus.equeueint_opcode;
    w_new.imm     = bus.equeue_imm;
    w_new.rdtag   = bus.equeue_rdtag;
    w_new.rstag   = bus.equeue_rstag;
    w_new.rttag   = bus.equeue_rttag;
    w_new.rsdata  = bus.equeue_rsdata;
    w_new.rtdata  = bus.equeue_rtdata;
    w_new.rsvalid = bus.equeue_rsvalid;
    w_new.rtvalid = bus.equeue_rtvalid;
    if (!bus.equeue_rsvalid && bus.cdb_valid && (bus.cdb_tag == bus.equeue_rstag)) begin
      w_new.rsvalid = 1'b1;
      w_new.rsdata  = bus.cdb_data;
    end
    if (!bus.equeue_rtvalid && bus.cdb_valid && (bus.cdb_tag == bus.equeue_rttag)) begin
      w_new.rtvalid = 1'b1;
      w_new.rtdata  = bus.cdb_data;
    end
  end

  // Wake in place, then compact over the issued slot, then append.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk[i] = r_q[i];
      if (w_wake_rs[i]) begin
        w_wk[i].rsvalid = 1'b1;
        w_wk[i].rsdata  = bus.cdb_data;
      end
      if (w_wake_rt[i]) begin
        w_wk[i].rtvalid = 1'b1;
        w_wk[i].rtdata  = bus.cdb_data;
      end
    end
    w_wk[DEPTH] = '0;

    w_wr_idx    = r_count - c_w_cnt'(w_deq);
    w_count_nxt = w_wr_idx + c_w_cnt'(w_enq);

    for (int i = 0; i < DEPTH; i++) begin
      if (w_deq && (c_w_cnt'(i) >= w_sel)) begin
        w_nxt[i] = w_wk[i+1];
      end else begin
        w_nxt[i] = w_wk[i];
      end
      if (w_enq && (c_w_cnt'(i) == w_wr_idx)) begin
        w_nxt[i] = w_new;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= w_nxt[i];
      end
    end
  end

  assign bus.equeueint_ready = w_ready;
  assign bus.issue_valid     = w_sel_found;
  assign bus.issue_opcode    = w_iss_opcode;
  assign bus.issue_rsdata    = w_iss_rsdata;
  assign bus.issue_rtdata    = w_iss_rtdata;
  assign bus.issue_imm       = w_iss_imm;
  assign bus.issue_rdtag     = w_iss_rdtag;
  assign bus.count           = r_count;

endmodule
`default_nettype wire

// File: tb/tb_equeue_int.sv
`default_nettype none
// ============================================================================
// Module   : tb_equeue_int
// Brief    : Directed scenarios plus random traffic against a queue model.
// Revision : 1.0
// ============================================================================
module tb_equeue_int;
  localparam int DEPTH   = 4;
  localparam int W_TAG   = 6;
  localparam int W_DATA  = 32;
  localparam int c_w_cnt = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  equeue_int_if #(.DEPTH(DEPTH), .W_TAG(W_TAG), .W_DATA(W_DATA)) bus ();

  equeue_int #(.DEPTH(DEPTH), .W_TAG(W_TAG), .W_DATA(W_DATA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]        op;
    logic [15:0]       imm;
    logic [W_TAG-1:0]  rd;
    logic [W_TAG-1:0]  rs;
    logic [W_TAG-1:0]  rt;
    logic [W_DATA-1:0] rsd;
    logic [W_DATA-1:0] rtd;
    bit                rsv;
    bit                rtv;
  } ment_t;

  ment_t mq[$];

  bit                 exp_valid;
  int                 exp_idx;
  logic [3:0]         exp_op;
  logic [W_DATA-1:0]  exp_rsd;
  logic [W_DATA-1:0]  exp_rtd;
  logic [15:0]        exp_imm;
  logic [W_TAG-1:0]   exp_rd;
  logic [c_w_cnt-1:0] exp_count;
  bit                 exp_ready;

  // Oldest entry whose operands are both available wins.
  function automatic void calc_exp();
    bit               rv;
    bit               tv;
    logic [W_DATA-1:0] sd;
    logic [W_DATA-1:0] td;
    exp_valid = 1'b0; exp_idx = 0; exp_op = '0; exp_rsd = '0;
    exp_rtd = '0; exp_imm = '0; exp_rd = '0;
    for (int i = 0; i < mq.size(); i++) begin
      rv = mq[i].rsv; tv = mq[i].rtv; sd = mq[i].rsd; td = mq[i].rtd;
`ifdef EQUEUEINT_WAKEUP_BYPASS_EN
      if (!rv && bus.cdb_valid && bus.cdb_tag == mq[i].rs) begin rv = 1; sd = bus.cdb_data; end
      if (!tv && bus.cdb_valid && bus.cdb_tag == mq[i].rt) begin tv = 1; td = bus.cdb_data; end
`endif
      if (rv && tv && !exp_valid) begin
        exp_valid = 1'b1; exp_idx = i; exp_op = mq[i].op; exp_rsd = sd;
        exp_rtd = td; exp_imm = mq[i].imm; exp_rd = mq[i].rd;
      end
    end
    exp_count = c_w_cnt'(mq.size());
    exp_ready = (mq.size() < DEPTH);
  endfunction

  function automatic void model_update();
    ment_t e;
    bit    acc;
    acc = bus.equeueint_en && (mq.size() < DEPTH);
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].rsv && bus.cdb_valid && bus.cdb_tag == mq[i].rs) begin mq[i].rsv = 1; mq[i].rsd = bus.cdb_data; end
      if (!mq[i].rtv && bus.cdb_valid && bus.cdb_tag == mq[i].rt) begin mq[i].rtv = 1; mq[i].rtd = bus.cdb_data; end
    end
    if (exp_valid && bus.issue_ready) mq.delete(exp_idx);
    if (acc) begin
      e.op = bus.equeueint_opcode; e.imm = bus.equeue_imm; e.rd = bus.equeue_rdtag;
      e.rs = bus.equeue_rstag; e.rt = bus.equeue_rttag;
      e.rsd = bus.equeue_rsdata; e.rtd = bus.equeue_rtdata;
      e.rsv = bus.equeue_rsvalid; e.rtv = bus.equeue_rtvalid;
      if (!e.rsv && bus.cdb_valid && bus.cdb_tag == e.rs) begin e.rsv = 1; e.rsd = bus.cdb_data; end
      if (!e.rtv && bus.cdb_valid && bus.cdb_tag == e.rt) begin e.rtv = 1; e.rtd = bus.cdb_data; end
      mq.push_back(e);
    end
  endfunction

  task automatic clk_step();
    calc_exp();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    calc_exp();
  endtask

  task automatic drive_enq(input logic [3:0] op, input logic [W_TAG-1:0] rd,
                           input logic [W_TAG-1:0] rs, input bit rsv, input logic [W_DATA-1:0] rsd,
                           input logic [W_TAG-1:0] rt, input bit rtv, input logic [W_DATA-1:0] rtd,
                           input logic [15:0] imm);
    bus.equeueint_en = 1'b1; bus.equeueint_opcode = op; bus.equeue_rdtag = rd;
    bus.equeue_rstag = rs; bus.equeue_rsvalid = rsv; bus.equeue_rsdata = rsd;
    bus.equeue_rttag = rt; bus.equeue_rtvalid = rtv; bus.equeue_rtdata = rtd;
    bus.equeue_imm = imm;
  endtask

  task automatic drive_cdb(input bit v, input logic [W_TAG-1:0] tag, input logic [W_DATA-1:0] data);
    bus.cdb_valid = v; bus.cdb_tag = tag; bus.cdb_data = data;
  endtask

  task automatic idle();
    bus.equeueint_en = 1'b0; bus.equeueint_opcode = '0; bus.equeue_rdtag = '0;
    bus.equeue_rstag = '0; bus.equeue_rsvalid = 1'b0; bus.equeue_rsdata = '0;
    bus.equeue_rttag = '0; bus.equeue_rtvalid = 1'b0; bus.equeue_rtdata = '0;
    bus.equeue_imm = '0;
    drive_cdb(1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); bus.issue_ready = 1'b0;
    repeat (2) @(negedge clk);
    settle();
    total++;
    if ({bus.count, bus.equeueint_ready, bus.issue_valid, bus.issue_rsdata, bus.issue_rdtag} !==
        {c_w_cnt'(0), 1'b1, 1'b0, 32'd0, 6'd0}) begin
      bad++; $display("FAIL reset_state: count=%0d ready=%0b valid=%0b want 0/1/0", bus.count, bus.equeueint_ready, bus.issue_valid);
    end
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_enq(4'h1, 6'(40 + k), 6'(40 + k), 1'b0, '0, 6'd0, 1'b1, 32'd1, 16'd0);
      clk_step();
    end
    idle(); settle();
    total++;
    if (bus.count !== c_w_cnt'(3)) begin bad++; $display("FAIL prefill_count: got %0d want 3", bus.count); end
    reset = 1'b0; #1;
    total++;
    if ({bus.count, bus.equeueint_ready, bus.issue_valid} !== {c_w_cnt'(0), 1'b1, 1'b0}) begin
      bad++; $display("FAIL async_reset: count=%0d ready=%0b valid=%0b want 0/1/0", bus.count, bus.equeueint_ready, bus.issue_valid);
    end
    mq.delete();
    @(negedge clk); reset = 1'b1;
    drive_enq(4'h2, 6'd5, 6'd0, 1'b1, 32'd10, 6'd0, 1'b1, 32'd20, 16'd0);
    clk_step(); idle(); settle();
    total++;
    if ({bus.issue_valid, bus.issue_opcode, bus.issue_rdtag, bus.issue_rsdata, bus.issue_rtdata} !==
        {1'b1, 4'h2, 6'd5, 32'd10, 32'd20}) begin
      bad++; $display("FAIL first_enqueue: valid=%0b op=%h rd=%0d rs=%0d rt=%0d want 1/2/5/10/20",
                      bus.issue_valid, bus.issue_opcode, bus.issue_rdtag, bus.issue_rsdata, bus.issue_rtdata);
    end
    bus.issue_ready = 1'b1; clk_step(); bus.issue_ready = 1'b0; settle();
    total++;
    if (bus.count !== c_w_cnt'(0)) begin bad++; $display("FAIL first_drain: count=%0d want 0", bus.count); end
  endtask

  task automatic test_wakeup();
    bus.issue_ready = 1'b0;
    drive_enq(4'h3, 6'd11, 6'd7, 1'b0, '0, 6'd12, 1'b1, 32'h1234, 16'h00AA);
    clk_step(); idle();
    drive_cdb(1'b1, 6'd8, 32'hCAFE0000); settle();
    total++;
    if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL wrong_tag: valid=%0b want 0", bus.issue_valid); end
    clk_step();
    drive_cdb(1'b1, 6'd7, 32'hDEADBEEF); settle();
    total++;
`ifdef EQUEUEINT_WAKEUP_BYPASS_EN
    if ({bus.issue_valid, bus.issue_rsdata} !== {1'b1, 32'hDEADBEEF}) begin
      bad++; $display("FAIL bypass_wake: valid=%0b rs=%h want 1/deadbeef", bus.issue_valid, bus.issue_rsdata);
    end
`else
    if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL wake_latency: valid=%0b want 0", bus.issue_valid); end
`endif
    clk_step(); drive_cdb(1'b0, '0, '0); settle();
    total++;
    if ({bus.issue_valid, bus.issue_rsdata, bus.issue_rtdata, bus.issue_imm, bus.issue_rdtag} !==
        {1'b1, 32'hDEADBEEF, 32'h1234, 16'h00AA, 6'd11}) begin
      bad++; $display("FAIL woken_issue: valid=%0b rs=%h rt=%h want 1/deadbeef/1234", bus.issue_valid, bus.issue_rsdata, bus.issue_rtdata);
    end
    bus.issue_ready = 1'b1; clk_step(); bus.issue_ready = 1'b0;
  endtask

  task automatic test_capture();
    bus.issue_ready = 1'b0;
    drive_enq(4'h5, 6'd13, 6'd1, 1'b1, 32'h77, 6'd9, 1'b0, '0, 16'd0);
    drive_cdb(1'b1, 6'd9, 32'h55);
    clk_step(); idle(); settle();
    total++;
    if ({bus.issue_valid, bus.issue_rtdata, bus.issue_rsdata} !== {1'b1, 32'h55, 32'h77}) begin
      bad++; $display("FAIL enq_capture: valid=%0b rt=%h rs=%h want 1/55/77", bus.issue_valid, bus.issue_rtdata, bus.issue_rsdata);
    end
    bus.issue_ready = 1'b1; clk_step(); bus.issue_ready = 1'b0;
  endtask

  task automatic test_age();
    bus.issue_ready = 1'b0;
    drive_enq(4'h1, 6'd1, 6'd3, 1'b0, '0, 6'd0, 1'b1, 32'hA, 16'd0); clk_step();
    drive_enq(4'h1, 6'd2, 6'd0, 1'b1, 32'hB, 6'd0, 1'b1, 32'hB, 16'd0); clk_step();
    drive_enq(4'h1, 6'd3, 6'd0, 1'b1, 32'hC, 6'd0, 1'b1, 32'hC, 16'd0); clk_step();
    idle(); settle();
    total++;
    if ({bus.count, bus.issue_valid, bus.issue_rdtag} !== {c_w_cnt'(3), 1'b1, 6'd2}) begin
      bad++; $display("FAIL age_b_first: count=%0d rd=%0d want 3/2", bus.count, bus.issue_rdtag);
    end
    bus.issue_ready = 1'b1; clk_step(); settle();
    total++;
    if ({bus.count, bus.issue_valid, bus.issue_rdtag} !== {c_w_cnt'(2), 1'b1, 6'd3}) begin
      bad++; $display("FAIL age_c_second: count=%0d rd=%0d want 2/3", bus.count, bus.issue_rdtag);
    end
    clk_step(); settle();
    total++;
    if ({bus.count, bus.issue_valid} !== {c_w_cnt'(1), 1'b0}) begin
      bad++; $display("FAIL age_a_waits: count=%0d valid=%0b want 1/0", bus.count, bus.issue_valid);
    end
    drive_cdb(1'b1, 6'd3, 32'h33); settle();
`ifdef EQUEUEINT_WAKEUP_BYPASS_EN
    total++;
    if ({bus.issue_valid, bus.issue_rdtag, bus.issue_rsdata} !== {1'b1, 6'd1, 32'h33}) begin
      bad++; $display("FAIL age_a_bypass: valid=%0b rd=%0d want 1/1", bus.issue_valid, bus.issue_rdtag);
    end
    clk_step();
`else
    clk_step(); drive_cdb(1'b0, '0, '0); settle();
    total++;
    if ({bus.issue_valid, bus.issue_rdtag, bus.issue_rsdata} !== {1'b1, 6'd1, 32'h33}) begin
      bad++; $display("FAIL age_a_last: valid=%0b rd=%0d rs=%h want 1/1/33", bus.issue_valid, bus.issue_rdtag, bus.issue_rsdata);
    end
    clk_step();
`endif
    drive_cdb(1'b0, '0, '0); settle();
    total++;
    if (bus.count !== c_w_cnt'(0)) begin bad++; $display("FAIL age_empty: count=%0d want 0", bus.count); end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_full();
    bus.issue_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive_enq(4'h7, 6'(16 + k), 6'd0, 1'b1, 32'(k), 6'd0, 1'b1, 32'(k), 16'd0);
      clk_step();
    end
    idle(); settle();
    total++;
    if ({bus.count, bus.equeueint_ready} !== {c_w_cnt'(DEPTH), 1'b0}) begin
      bad++; $display("FAIL full_flag: count=%0d ready=%0b want 4/0", bus.count, bus.equeueint_ready);
    end
    drive_enq(4'h7, 6'd30, 6'd0, 1'b1, '0, 6'd0, 1'b1, '0, 16'd0);
    clk_step(); idle(); settle();
    total++;
    if ({bus.count, bus.issue_rdtag} !== {c_w_cnt'(DEPTH), 6'd16}) begin
      bad++; $display("FAIL full_drop: count=%0d head=%0d want 4/16", bus.count, bus.issue_rdtag);
    end
    bus.issue_ready = 1'b1;
    drive_enq(4'h7, 6'd31, 6'd0, 1'b1, '0, 6'd0, 1'b1, '0, 16'd0);
    clk_step(); settle();
    total++;
    if ({bus.count, bus.equeueint_ready} !== {c_w_cnt'(3), 1'b1}) begin
      bad++; $display("FAIL no_credit: count=%0d ready=%0b want 3/1", bus.count, bus.equeueint_ready);
    end
    drive_enq(4'h7, 6'd32, 6'd0, 1'b1, '0, 6'd0, 1'b1, '0, 16'd0);
    clk_step(); idle(); settle();
    total++;
    if ({bus.count, bus.issue_rdtag} !== {c_w_cnt'(3), 6'd18}) begin
      bad++; $display("FAIL enq_deq: count=%0d head=%0d want 3/18", bus.count, bus.issue_rdtag);
    end
    clk_step(); clk_step(); settle();
    total++;
    if ({bus.count, bus.issue_rdtag} !== {c_w_cnt'(1), 6'd32}) begin
      bad++; $display("FAIL tail_slot: count=%0d rd=%0d want 1/32", bus.count, bus.issue_rdtag);
    end
    clk_step(); bus.issue_ready = 1'b0;
  endtask

  task automatic test_stall();
    bus.issue_ready = 1'b0;
    drive_enq(4'hA, 6'd21, 6'd0, 1'b1, 32'h11112222, 6'd0, 1'b1, 32'h33334444, 16'hBEEF);
    clk_step();
    drive_enq(4'h4, 6'd22, 6'd50, 1'b0, '0, 6'd0, 1'b1, 32'd0, 16'd0);
    for (int c = 0; c < 5; c++) begin
      drive_cdb(1'b1, 6'(55 + c), $urandom());
      settle();
      total++;
      if ({bus.issue_valid, bus.issue_opcode, bus.issue_rdtag, bus.issue_rsdata, bus.issue_rtdata, bus.issue_imm} !==
          {1'b1, 4'hA, 6'd21, 32'h11112222, 32'h33334444, 16'hBEEF}) begin
        bad++; $display("FAIL stall_%0d: valid=%0b op=%h rd=%0d rs=%h rt=%h imm=%h", c, bus.issue_valid,
                        bus.issue_opcode, bus.issue_rdtag, bus.issue_rsdata, bus.issue_rtdata, bus.issue_imm);
      end
      clk_step();
      bus.equeueint_en = 1'b0;
    end
    idle();
    drive_cdb(1'b1, 6'd50, 32'd9);
    bus.issue_ready = 1'b1; clk_step(); drive_cdb(1'b0, '0, '0);
    repeat (2) clk_step();
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [94:0] got;
    logic [94:0] want;
    for (int c = 0; c < 1500; c++) begin
      drive_enq(4'($urandom()), 6'($urandom()), 6'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                $urandom(), 6'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1), $urandom(), 16'($urandom()));
      bus.equeueint_en = ($urandom_range(0, 9) < 6);
      drive_cdb(($urandom_range(0, 1) == 1), 6'($urandom_range(0, 7)), $urandom());
      bus.issue_ready = ($urandom_range(0, 9) < 6);
      settle();
      got  = {bus.issue_valid, bus.issue_opcode, bus.issue_rsdata, bus.issue_rtdata, bus.issue_imm,
              bus.issue_rdtag, bus.count, bus.equeueint_ready};
      want = {exp_valid, exp_op, exp_rsd, exp_rtd, exp_imm, exp_rd, exp_count, exp_ready};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL random_cycle_%0d: got %h want %h", c, got, want);
      end
      clk_step();
    end
    idle(); bus.issue_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wakeup();
    test_capture();
    test_age();
    test_full();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
